// File: rtl/scomp_arb_pkg.sv
// ----------------------------------------------------------------------------
// scomp_arb_pkg
//   Shared definitions for the shared-comparator arbiter:
//   - FSM state encoding (S_IDLE / S_CMP / S_DONE) and its enum type
//   - idw_f(): requester-index width helper (ceil(log2(n)), minimum 1)
// ----------------------------------------------------------------------------
package scomp_arb_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMP  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_CMP  = S_CMP,
    ST_DONE = S_DONE
  } state_e;

  // ceil(log2(n)), used only for elaboration-time widths
  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < n) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Width of a requester index; at least one bit so ports never collapse
  function automatic int idw_f(input int nreq);
    return (nreq < 2) ? 1 : clog2_f(nreq);
  endfunction

endpackage

// File: rtl/rr_arb_core.sv
// ----------------------------------------------------------------------------
// rr_arb_core
//   Purely combinational round-robin pick. Searches req upward starting at
//   rr_ptr (wrapping NREQ-1 -> 0) and reports the first set request.
// Ports
//   req    in   NREQ  pending requests
//   rr_ptr in   IDW   search start index (always < NREQ)
//   en     in   1     grant allowed this cycle
//   gnt    out  NREQ  one-hot grant (zero when !en or no request)
//   winner out  IDW   index of the picked request (valid when any=1)
//   any    out  1     a grant is being issued
// ----------------------------------------------------------------------------
module rr_arb_core
  import scomp_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = idw_f(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  winner,
  output logic            any
);

  logic [IDW:0] idx_s;
  logic         found_s;

  // Priority search from rr_ptr with modulo-NREQ wrap
  always_comb begin
    found_s = 1'b0;
    winner  = '0;
    idx_s   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s = {1'b0, rr_ptr} + (IDW+1)'(k);
      // rr_ptr < NREQ and k < NREQ, so one subtraction suffices for the wrap
      if (idx_s >= (IDW+1)'(NREQ)) begin
        idx_s = idx_s - (IDW+1)'(NREQ);
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && req[idx_s[IDW-1:0]]) begin
        found_s = 1'b1;
        winner  = idx_s[IDW-1:0];
      end else begin
        found_s = found_s;
      end
    end
    any = en & found_s;
    if (any) begin
      gnt = NREQ'(1'b1) << winner;
    end else begin
      gnt = '0;
    end
  end

endmodule

// File: rtl/scomp_arbiter.sv
// ----------------------------------------------------------------------------
// scomp_arbiter
//   Shares one registered magnitude comparator between NREQ requesters.
//   A round-robin pick latches the winner's operand pair, the next cycle
//   registers the compare, and the result is held until res_ready.
//   Configuration macro: SCOMP_ARB_SIGNED_EN -- when defined, operands are
//   compared as two's-complement; otherwise unsigned (default).
// Ports
//   Clk        in   1               clock, rising edge
//   Rst_n      in   1               asynchronous active-low reset
//   req        in   NREQ            per-requester request, held until granted
//   a_bus      in   NREQ*DATAWIDTH  operand a, requester i at [i*DATAWIDTH +: DATAWIDTH]
//   b_bus      in   NREQ*DATAWIDTH  operand b, same packing
//   gnt        out  NREQ            one-hot grant; operands sampled at this edge
//   res_valid  out  1               result valid
//   res_ready  in   1               downstream accepts result
//   res_id     out  IDW             requester that owns the result
//   res_gt     out  1               a > b
//   res_lt     out  1               a < b
//   res_eq     out  1               a == b
// ----------------------------------------------------------------------------
module scomp_arbiter
  import scomp_arb_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int NREQ      = 4,
  parameter int IDW       = idw_f(NREQ)
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*DATAWIDTH-1:0] a_bus,
  input  logic [NREQ*DATAWIDTH-1:0] b_bus,
  output logic [NREQ-1:0]           gnt,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [IDW-1:0]            res_id,
  output logic                      res_gt,
  output logic                      res_lt,
  output logic                      res_eq
);

  state_e               state_q, state_d;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [DATAWIDTH-1:0] a_q, a_d;
  logic [DATAWIDTH-1:0] b_q, b_d;
  logic [IDW-1:0]       id_q, id_d;
  logic                 res_valid_q, res_valid_d;
  logic [IDW-1:0]       res_id_q, res_id_d;
  logic                 res_gt_q, res_gt_d;
  logic                 res_lt_q, res_lt_d;
  logic                 res_eq_q, res_eq_d;

  logic                 arb_en_s;
  logic [NREQ-1:0]      arb_gnt_s;
  logic [IDW-1:0]       arb_winner_s;
  logic                 arb_any_s;
  logic [DATAWIDTH-1:0] a_sel_s, b_sel_s;
  logic                 gt_s, lt_s, eq_s;

  // Grant points: IDLE, or DONE while the result is being accepted.
  // Rst_n gates it so gnt drops immediately when reset asserts.
  assign arb_en_s = Rst_n & ((state_q == ST_IDLE) |
                             ((state_q == ST_DONE) & res_ready));

  rr_arb_core #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .en     (arb_en_s),
    .gnt    (arb_gnt_s),
    .winner (arb_winner_s),
    .any    (arb_any_s)
  );

  // AND-OR operand mux driven by the one-hot grant
  always_comb begin
    a_sel_s = '0;
    b_sel_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_sel_s = a_sel_s | ({DATAWIDTH{arb_gnt_s[i]}} & a_bus[i*DATAWIDTH +: DATAWIDTH]);
      b_sel_s = b_sel_s | ({DATAWIDTH{arb_gnt_s[i]}} & b_bus[i*DATAWIDTH +: DATAWIDTH]);
    end
  end

`ifdef SCOMP_ARB_SIGNED_EN
  assign gt_s = $signed(a_q) > $signed(b_q);
  assign lt_s = $signed(a_q) < $signed(b_q);
`else
  assign gt_s = a_q > b_q;
  assign lt_s = a_q < b_q;
`endif
  assign eq_s = (a_q == b_q);

  // Operand/id capture and pointer advance, only on an issued grant
  always_comb begin
    if (arb_any_s) begin
      a_d  = a_sel_s;
      b_d  = b_sel_s;
      id_d = arb_winner_s;
      if (arb_winner_s == IDW'(NREQ-1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = arb_winner_s + IDW'(1);
      end
    end else begin
      a_d      = a_q;
      b_d      = b_q;
      id_d     = id_q;
      rr_ptr_d = rr_ptr_q;
    end
  end

  // FSM next state and result register update
  always_comb begin
    state_d     = state_q;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_gt_d    = res_gt_q;
    res_lt_d    = res_lt_q;
    res_eq_d    = res_eq_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_any_s) begin
          state_d = ST_CMP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CMP: begin
        state_d     = ST_DONE;
        res_valid_d = 1'b1;
        res_id_d    = id_q;
        res_gt_d    = gt_s;
        res_lt_d    = lt_s;
        res_eq_d    = eq_s;
      end
      ST_DONE: begin
        if (res_ready) begin
          // Flags clear with valid so none is set while res_valid=0
          res_valid_d = 1'b0;
          res_gt_d    = 1'b0;
          res_lt_d    = 1'b0;
          res_eq_d    = 1'b0;
          if (arb_any_s) begin
            state_d = ST_CMP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        res_valid_d = 1'b0;
        res_gt_d    = 1'b0;
        res_lt_d    = 1'b0;
        res_eq_d    = 1'b0;
      end
    endcase
  end

  // State, operand and result registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_gt_q    <= 1'b0;
      res_lt_q    <= 1'b0;
      res_eq_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_gt_q    <= res_gt_d;
      res_lt_q    <= res_lt_d;
      res_eq_q    <= res_eq_d;
    end
  end

  assign gnt       = arb_gnt_s;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_gt    = res_gt_q;
  assign res_lt    = res_lt_q;
  assign res_eq    = res_eq_q;

endmodule

// File: tb/tb_scomp_arbiter.sv
// ----------------------------------------------------------------------------
// tb_scomp_arbiter
//   Directed self-checking bench for scomp_arbiter (DATAWIDTH=8, NREQ=4).
//   Inputs change 1ns after a rising edge; outputs are sampled at the
//   falling edge (or 1ns after an asynchronous reset assertion).
// ----------------------------------------------------------------------------
module tb_scomp_arbiter;

  localparam int DW   = 8;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              Clk;
  logic              Rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*DW-1:0] a_bus;
  logic [NREQ*DW-1:0] b_bus;
  logic [NREQ-1:0]   gnt;
  logic              res_valid;
  logic              res_ready;
  logic [IDW-1:0]    res_id;
  logic              res_gt;
  logic              res_lt;
  logic              res_eq;

  int n_checks;
  int n_fail;

  scomp_arbiter #(
    .DATAWIDTH (DW),
    .NREQ      (NREQ)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .req       (req),
    .a_bus     (a_bus),
    .b_bus     (b_bus),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_gt    (res_gt),
    .res_lt    (res_lt),
    .res_eq    (res_eq)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic edge_t();
    @(posedge Clk);
    #1;
  endtask

  task automatic mid_t();
    @(negedge Clk);
  endtask

  task automatic set_op(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b);
    a_bus[idx*DW +: DW] = a;
    b_bus[idx*DW +: DW] = b;
  endtask

  // Issue one isolated transaction and return observed grant and result
  // {res_valid, res_id, res_gt, res_lt, res_eq}; leaves the DUT in IDLE.
  task automatic do_txn(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        output logic [NREQ-1:0] g, output logic [5:0] r);
    set_op(idx, a, b);
    req = '0;
    req[idx] = 1'b1;
    res_ready = 1'b0;
    mid_t();
    g = gnt;
    edge_t();
    req = '0;
    edge_t();
    mid_t();
    r = {res_valid, res_id, res_gt, res_lt, res_eq};
    res_ready = 1'b1;
    edge_t();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    repeat (2) edge_t();
    mid_t();
    n_checks++;
    obs = {gnt, res_valid, res_id, res_gt, res_lt, res_eq};
    if (obs !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_hold: got %b expected %b", obs, 10'd0);
    end
    edge_t();
    Rst_n = 1'b1;
    mid_t();
    n_checks++;
    if ({gnt, res_valid} !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_release: got %b expected %b", {gnt, res_valid}, 5'd0);
    end
    // Complete one transaction so res_id is non-zero, then start another
    edge_t();
    set_op(2, 8'h30, 8'h10);
    req = 4'b0100;
    mid_t();
    edge_t();
    req = 4'b0000;
    edge_t();
    mid_t();
    n_checks++;
    if ({res_valid, res_id, res_gt, res_lt, res_eq} !== 6'b110100) begin
      n_fail++;
      $display("FAIL reset_pre_txn: got %b expected %b",
               {res_valid, res_id, res_gt, res_lt, res_eq}, 6'b110100);
    end
    res_ready = 1'b1;
    edge_t();
    res_ready = 1'b0;
    set_op(1, 8'h01, 8'h02);
    req = 4'b0010;
    mid_t();
    edge_t();
    req = 4'b1111;
    // In CMP now: assert reset between edges
    #2;
    Rst_n = 1'b0;
    #1;
    n_checks++;
    obs = {gnt, res_valid, res_id, res_gt, res_lt, res_eq};
    if (obs !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_async: got %b expected %b", obs, 10'd0);
    end
    req = 4'b0000;
    edge_t();
    edge_t();
    Rst_n = 1'b1;
    mid_t();
    n_checks++;
    if ({gnt, res_valid} !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_idle: got %b expected %b", {gnt, res_valid}, 5'd0);
    end
  endtask

  // All four requesting with res_ready held: order 0,1,2,3,0 from rr_ptr=0
  task automatic test_fairness();
    logic [NREQ-1:0] exp_g [0:10];
    logic [3:0]      exp_r [0:10];
    logic [IDW-1:0]  exp_id [0:10];
    exp_g  = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000,
               4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
    exp_r  = '{4'b0000, 4'b0000, 4'b1100, 4'b0000, 4'b1010, 4'b0000,
               4'b1001, 4'b0000, 4'b1100, 4'b0000, 4'b1100};
    exp_id = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd0, 2'd0};
    edge_t();
    set_op(0, 8'h05, 8'h03);
    set_op(1, 8'h02, 8'h09);
    set_op(2, 8'h07, 8'h07);
    set_op(3, 8'hFF, 8'h00);
    req = 4'b1111;
    res_ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      mid_t();
      n_checks++;
      if (gnt !== exp_g[c]) begin
        n_fail++;
        $display("FAIL fair_gnt[%0d]: got %b expected %b", c, gnt, exp_g[c]);
      end
      n_checks++;
      if ({res_valid, res_gt, res_lt, res_eq} !== exp_r[c]) begin
        n_fail++;
        $display("FAIL fair_res[%0d]: got %b expected %b", c,
                 {res_valid, res_gt, res_lt, res_eq}, exp_r[c]);
      end
      if (exp_r[c][3]) begin
        n_checks++;
        if (res_id !== exp_id[c]) begin
          n_fail++;
          $display("FAIL fair_id[%0d]: got %0d expected %0d", c, res_id, exp_id[c]);
        end
      end
      edge_t();
      if (c == 8) begin
        req = 4'b0000;
      end
    end
    res_ready = 1'b0;
  endtask

  task automatic test_single();
    set_op(2, 8'h30, 8'h10);
    req = 4'b0100;
    res_ready = 1'b0;
    mid_t();
    n_checks++;
    if (gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_gnt: got %b expected %b", gnt, 4'b0100);
    end
    edge_t();
    req = 4'b0000;
    mid_t();
    n_checks++;
    if ({gnt, res_valid} !== 5'b00000) begin
      n_fail++;
      $display("FAIL single_cmp: got %b expected %b", {gnt, res_valid}, 5'b00000);
    end
    edge_t();
    mid_t();
    n_checks++;
    if ({res_valid, res_id, res_gt, res_lt, res_eq} !== 6'b110100) begin
      n_fail++;
      $display("FAIL single_res: got %b expected %b",
               {res_valid, res_id, res_gt, res_lt, res_eq}, 6'b110100);
    end
    res_ready = 1'b1;
    edge_t();
    res_ready = 1'b0;
    mid_t();
    n_checks++;
    if ({res_valid, res_gt, res_lt, res_eq} !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_accept: got %b expected %b",
               {res_valid, res_gt, res_lt, res_eq}, 4'b0000);
    end
    edge_t();
  endtask

  task automatic test_back_to_back();
    set_op(0, 8'h40, 8'h50);
    set_op(1, 8'h99, 8'h12);
    req = 4'b0001;
    res_ready = 1'b0;
    mid_t();
    n_checks++;
    if (gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL bp_gnt0: got %b expected %b", gnt, 4'b0001);
    end
    edge_t();
    req = 4'b0010;
    mid_t();
    n_checks++;
    if (gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL bp_cmp_gnt: got %b expected %b", gnt, 4'b0000);
    end
    edge_t();
    for (int k = 0; k < 5; k++) begin
      mid_t();
      n_checks++;
      if ({gnt, res_valid, res_id, res_gt, res_lt, res_eq} !== 10'b0000_100010) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got %b expected %b", k,
                 {gnt, res_valid, res_id, res_gt, res_lt, res_eq}, 10'b0000_100010);
      end
      edge_t();
    end
    res_ready = 1'b1;
    mid_t();
    n_checks++;
    if ({gnt, res_valid, res_id, res_gt, res_lt, res_eq} !== 10'b0010_100010) begin
      n_fail++;
      $display("FAIL bp_release: got %b expected %b",
               {gnt, res_valid, res_id, res_gt, res_lt, res_eq}, 10'b0010_100010);
    end
    edge_t();
    req = 4'b0000;
    res_ready = 1'b0;
    mid_t();
    n_checks++;
    if ({gnt, res_valid} !== 5'b00000) begin
      n_fail++;
      $display("FAIL bp_cmp2: got %b expected %b", {gnt, res_valid}, 5'b00000);
    end
    edge_t();
    mid_t();
    n_checks++;
    if ({res_valid, res_id, res_gt, res_lt, res_eq} !== 6'b101100) begin
      n_fail++;
      $display("FAIL bp_res2: got %b expected %b",
               {res_valid, res_id, res_gt, res_lt, res_eq}, 6'b101100);
    end
    res_ready = 1'b1;
    edge_t();
    res_ready = 1'b0;
  endtask

  task automatic test_eq_lt();
    logic [NREQ-1:0] g;
    logic [5:0]      r;
    do_txn(3, 8'hA5, 8'hA5, g, r);
    n_checks++;
    if ({g, r} !== {4'b1000, 6'b111001}) begin
      n_fail++;
      $display("FAIL eq: got %b expected %b", {g, r}, {4'b1000, 6'b111001});
    end
    do_txn(0, 8'h01, 8'h00, g, r);
    n_checks++;
    if ({g, r} !== {4'b0001, 6'b100100}) begin
      n_fail++;
      $display("FAIL gt_small: got %b expected %b", {g, r}, {4'b0001, 6'b100100});
    end
  endtask

  task automatic test_signed();
    logic [NREQ-1:0] g;
    logic [5:0]      r;
    logic [5:0]      exp_r;
`ifdef SCOMP_ARB_SIGNED_EN
    exp_r = 6'b100100;
`else
    exp_r = 6'b100010;
`endif
    do_txn(0, 8'h01, 8'hFE, g, r);
    n_checks++;
    if ({g, r} !== {4'b0001, exp_r}) begin
      n_fail++;
      $display("FAIL sign_cmp: got %b expected %b", {g, r}, {4'b0001, exp_r});
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    Rst_n     = 1'b0;
    req       = '0;
    a_bus     = '0;
    b_bus     = '0;
    res_ready = 1'b0;
    test_reset();
    test_fairness();
    test_single();
    test_back_to_back();
    test_eq_lt();
    test_signed();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
